// File: rtl/hazard_control_unit.sv
// Hazard controller beside ID: load-use stalls, branch flush, EX forwarding.
// Ports: clk, async active-low reset, ID/EX/MEM/WB fields in; PC/IF-ID enables, NOP-select, flush, forward selects, event counters out.
module hazard_control_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_branch_taken,
  input  logic [3:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic [3:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [3:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             cu_nop_select,
  output logic             if_id_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, STALL} state_t;

  // Hazard cycle is the first bubble; STALL supplies the rest.
  localparam logic [2:0] CNT_INIT = 3'(STALL_CYCLES - 2);

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       hazard;
  logic       stalling;
  logic       flushing;
  logic       inc_stall;
  logic [1:0] fa, fb;

  function automatic logic [1:0] fwd(
    input logic       use_r,
    input logic [3:0] r,
    input logic       mw,
    input logic [3:0] mrd,
    input logic       ww,
    input logic [3:0] wrd
  );
    if (use_r && mw && mrd == r && mrd != 4'd15)
      return 2'b01;
    else if (use_r && ww && wrd == r && wrd != 4'd15)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    hazard = ex_reg_write && ex_mem_to_reg && ex_rd != 4'd15 &&
             ((id_use_rn && id_rn == ex_rd) ||
              (id_use_rm && id_rm == ex_rd));
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    stalling  = 1'b0;
    flushing  = 1'b0;
    inc_stall = 1'b0;
    case (state)
      RUN: begin
        if (hazard) begin
          stalling  = 1'b1;
          inc_stall = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_nx = STALL;
            cnt_nx   = CNT_INIT;
          end
        end else if (id_branch_taken) begin
          flushing = 1'b1;
        end
      end
      STALL: begin
        stalling = 1'b1;
        if (cnt == 3'd0)
          state_nx = RUN;
        else
          cnt_nx = cnt - 3'd1;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (inc_stall && stall_count != '1)
        stall_count <= stall_count + 1'b1;
      if (flushing && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

  always_comb begin
    fa = fwd(id_use_rn, id_rn, mem_reg_write, mem_rd,
             wb_reg_write, wb_rd);
    fb = fwd(id_use_rm, id_rm, mem_reg_write, mem_rd,
             wb_reg_write, wb_rd);
  end

  // Reset overrides the outputs combinationally, not just at the next edge.
  assign pc_enable     = reset & ~stalling;
  assign if_id_enable  = reset & ~stalling;
  assign cu_nop_select = ~reset | stalling;
  assign if_id_flush   = reset & flushing;
  assign forward_a     = reset ? fa : 2'b00;
  assign forward_b     = reset ? fb : 2'b00;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit.
// Two instances: 1-cycle stall/16-bit counters and 3-cycle stall/4-bit counters.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
  logic       id_use_rn, id_use_rm, id_branch_taken;
  logic       ex_reg_write, ex_mem_to_reg, mem_reg_write, wb_reg_write;

  logic        pe1, ie1, nop1, fl1, pe3, ie3, nop3, fl3;
  logic [1:0]  fa1, fb1, fa3, fb3;
  logic [15:0] sc1, fc1;
  logic [3:0]  sc3, fc3;

  always #5 clk = ~clk;

  hazard_control_unit #(.STALL_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_branch_taken(id_branch_taken),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_enable(pe1), .if_id_enable(ie1),
    .cu_nop_select(nop1), .if_id_flush(fl1),
    .forward_a(fa1), .forward_b(fb1),
    .stall_count(sc1), .flush_count(fc1)
  );

  hazard_control_unit #(.STALL_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_branch_taken(id_branch_taken),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_enable(pe3), .if_id_enable(ie3),
    .cu_nop_select(nop3), .if_id_flush(fl3),
    .forward_a(fa3), .forward_b(fb3),
    .stall_count(sc3), .flush_count(fc3)
  );

  typedef struct {
    logic [1:0] pe, ie, nop, fl;
    logic [1:0] fa, fb;
    int         sc0, fc0, sc1, fc1;
  } exp_t;

  exp_t q[$];
  int   n_err = 0;
  int   n_chk = 0;

  // Reference model: remaining bubbles and event totals per instance.
  int stall_len[2] = '{1, 3};
  int cnt_max[2]   = '{65535, 15};
  int rem[2]       = '{0, 0};
  int m_sc[2]      = '{0, 0};
  int m_fc[2]      = '{0, 0};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic u,
                                         input logic [3:0] r);
    if (!u) return 2'b00;
    if (mem_reg_write && mem_rd == r && mem_rd != 15) return 2'b01;
    if (wb_reg_write && wb_rd == r && wb_rd != 15) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step();
    exp_t e;
    logic hz;
    hz = ex_reg_write && ex_mem_to_reg && ex_rd != 15 &&
         ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd));
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        e.pe[i] = 0; e.ie[i] = 0; e.nop[i] = 1; e.fl[i] = 0;
      end else if (rem[i] > 0 || hz) begin
        e.pe[i] = 0; e.ie[i] = 0; e.nop[i] = 1; e.fl[i] = 0;
      end else begin
        e.pe[i] = 1; e.ie[i] = 1; e.nop[i] = 0;
        e.fl[i] = id_branch_taken;
      end
    end
    e.sc0 = m_sc[0]; e.fc0 = m_fc[0];
    e.sc1 = m_sc[1]; e.fc1 = m_fc[1];
    e.fa = reset ? ref_fwd(id_use_rn, id_rn) : 2'b00;
    e.fb = reset ? ref_fwd(id_use_rm, id_rm) : 2'b00;
    q.push_back(e);
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] > 0) begin
          rem[i]--;
        end else if (hz) begin
          if (m_sc[i] < cnt_max[i]) m_sc[i]++;
          rem[i] = stall_len[i] - 1;
        end else if (id_branch_taken) begin
          if (m_fc[i] < cnt_max[i]) m_fc[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rn = 4'd0; id_rm = 4'd0; id_use_rn = 0; id_use_rm = 0;
    id_branch_taken = 0;
    ex_rd = 4'd0; ex_reg_write = 0; ex_mem_to_reg = 0;
    mem_rd = 4'd0; mem_reg_write = 0;
    wb_rd = 4'd0; wb_reg_write = 0;
  endtask

  task automatic load_use(input logic [3:0] r);
    idle();
    ex_rd = r; ex_reg_write = 1; ex_mem_to_reg = 1;
    id_rm = r; id_use_rm = 1;
  endtask

  function automatic logic [3:0] rreg();
    int k;
    k = $urandom_range(0, 3);
    return (k == 3) ? 4'd15 : 4'(k);
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_enable_s1", pe1, e.pe[0]);
      chk("if_id_enable_s1", ie1, e.ie[0]);
      chk("cu_nop_select_s1", nop1, e.nop[0]);
      chk("if_id_flush_s1", fl1, e.fl[0]);
      chk("pc_enable_s3", pe3, e.pe[1]);
      chk("if_id_enable_s3", ie3, e.ie[1]);
      chk("cu_nop_select_s3", nop3, e.nop[1]);
      chk("if_id_flush_s3", fl3, e.fl[1]);
      chk("forward_a_s1", fa1, e.fa);
      chk("forward_b_s1", fb1, e.fb);
      chk("forward_a_s3", fa3, e.fa);
      chk("forward_b_s3", fb3, e.fb);
      chk("stall_count_s1", sc1, e.sc0);
      chk("flush_count_s1", fc1, e.fc0);
      chk("stall_count_s3", sc3, e.sc1);
      chk("flush_count_s3", fc3, e.fc1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle();
    @(posedge clk);
    #1;
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();

    // Load-use on Rm, then the load moves on to MEM.
    load_use(4'd2);
    step();
    idle();
    mem_rd = 4'd2; mem_reg_write = 1;
    id_rm = 4'd2; id_use_rm = 1;
    step();
    idle();
    repeat (3) step();

    // Taken branch alone, then together with a hazard.
    id_branch_taken = 1;
    step();
    idle();
    step();
    load_use(4'd3);
    id_branch_taken = 1;
    step();
    idle();
    id_branch_taken = 1;
    repeat (3) step();
    idle();
    repeat (3) step();

    // Forwarding priority and r15 exclusion.
    id_rn = 4'd5; id_use_rn = 1;
    mem_rd = 4'd5; mem_reg_write = 1;
    wb_rd = 4'd5; wb_reg_write = 1;
    step();
    mem_reg_write = 0;
    step();
    mem_rd = 4'd15; wb_rd = 4'd15; id_rn = 4'd15;
    mem_reg_write = 1;
    step();
    id_use_rn = 0; id_rn = 4'd5; mem_rd = 4'd5;
    step();
    idle();
    step();

    // Drive the 4-bit counter past saturation.
    for (int n = 0; n < 20; n++) begin
      load_use(4'(n % 15));
      step();
      idle();
      repeat (3) step();
    end

    // Reset asserted while the 3-cycle instance is in STALL.
    load_use(4'd7);
    step();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (2) step();

    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 59) != 0);
      id_rn = rreg(); id_rm = rreg();
      id_use_rn = 1'($urandom); id_use_rm = 1'($urandom);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      ex_rd = rreg();
      ex_reg_write = 1'($urandom); ex_mem_to_reg = 1'($urandom);
      mem_rd = rreg(); mem_reg_write = 1'($urandom);
      wb_rd = rreg(); wb_reg_write = 1'($urandom);
      step();
    end
    reset = 1'b1;
    idle();
    step();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
